// File: rtl/psum_requant_stage.sv
// psum_requant_stage
//   Accumulates a group of signed partial sums (terminated by in_last),
//   arithmetic-shifts the group sum right by SHIFT, optionally applies ReLU,
//   clamps it to the signed OUT_WIDTH range and presents it in a registered
//   output slot with a valid/ready handshake.
//
//   Optional feature: define PSUM_RELU_EN to zero negative shifted values
//   before clamping. Zeroing is not reported as saturation.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   partial sum presented
//   in_ready   stage accepts in_psum this cycle
//   in_psum    signed partial sum (ACC_WIDTH)
//   in_last    final partial sum of a group
//   out_valid  out_data holds a completed result
//   out_ready  downstream takes out_data this cycle
//   out_data   requantized group result (OUT_WIDTH, signed)
//   out_sat    result was clamped to a range limit
//   out_len    beats in the emitted group, saturating at 255
module psum_requant_stage #(
  parameter int ACC_WIDTH = 16,
  parameter int SUM_WIDTH = 24,
  parameter int OUT_WIDTH = 8,
  parameter int SHIFT     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ACC_WIDTH-1:0] in_psum,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_sat,
  output logic [7:0]           out_len
);

  // Clamp limits expressed in the accumulator width for signed comparison.
  localparam logic signed [SUM_WIDTH-1:0] SUM_MAX = SUM_WIDTH'(2**(OUT_WIDTH-1) - 1);
  localparam logic signed [SUM_WIDTH-1:0] SUM_MIN = ~SUM_MAX;
  localparam logic [OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  logic signed [SUM_WIDTH-1:0] sum_r;
  logic [7:0]                  cnt_r;
  logic                        first_r;

  logic                        accept_s;
  logic signed [SUM_WIDTH-1:0] psum_ext_s;
  logic signed [SUM_WIDTH-1:0] sum_next_s;
  logic [7:0]                  cnt_next_s;
  logic signed [SUM_WIDTH-1:0] shifted_s;
  logic [OUT_WIDTH-1:0]        res_data_s;
  logic                        res_sat_s;

  // Only a result stalled by the consumer blocks new beats.
  assign in_ready = ~(out_valid & ~out_ready);
  assign accept_s = in_valid & in_ready;

  // Running sum and beat count including the beat currently presented.
  always_comb begin
    psum_ext_s = SUM_WIDTH'($signed(in_psum));
    if (first_r) begin
      sum_next_s = psum_ext_s;
      cnt_next_s = 8'd1;
    end else begin
      sum_next_s = sum_r + psum_ext_s;
      cnt_next_s = (cnt_r == 8'd255) ? 8'd255 : cnt_r + 8'd1;
    end
  end

  // Requantize: arithmetic shift, optional ReLU, clamp to output range.
  always_comb begin
    shifted_s = sum_next_s >>> SHIFT;
`ifdef PSUM_RELU_EN
    if (shifted_s < $signed({SUM_WIDTH{1'b0}})) begin
      shifted_s = '0;
    end else begin
      shifted_s = shifted_s;
    end
`endif
    if (shifted_s > SUM_MAX) begin
      res_data_s = OUT_MAX;
      res_sat_s  = 1'b1;
    end else if (shifted_s < SUM_MIN) begin
      res_data_s = OUT_MIN;
      res_sat_s  = 1'b1;
    end else begin
      res_data_s = shifted_s[OUT_WIDTH-1:0];
      res_sat_s  = 1'b0;
    end
  end

  // Group accumulation state and registered output slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_r     <= '0;
      cnt_r     <= 8'd0;
      first_r   <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
      out_len   <= 8'd0;
    end else if (accept_s && in_last) begin
      // Close the group; the next accepted beat starts a fresh one.
      sum_r     <= sum_next_s;
      cnt_r     <= 8'd0;
      first_r   <= 1'b1;
      out_valid <= 1'b1;
      out_data  <= res_data_s;
      out_sat   <= res_sat_s;
      out_len   <= cnt_next_s;
    end else begin
      if (accept_s) begin
        sum_r   <= sum_next_s;
        cnt_r   <= cnt_next_s;
        first_r <= 1'b0;
      end else begin
        sum_r   <= sum_r;
        cnt_r   <= cnt_r;
        first_r <= first_r;
      end
      if (out_ready) begin
        out_valid <= 1'b0;
      end else begin
        out_valid <= out_valid;
      end
    end
  end

endmodule
